// File: rtl/rename_pkg.sv
// Shared state type and width helper for the rename group splitter.
package rename_pkg;

    typedef enum logic {
        NORMAL = 1'b0,
        SPLIT  = 1'b1
    } split_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/rename_group_splitter_if.sv
// Decode-to-rename bundle: group masks and stalls in, slice and slot info out.
interface rename_group_splitter_if
    import rename_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int PERF_W = 16
);
    localparam int LW = clog2(WIDTH);
    localparam int CW = clog2(WIDTH + 1);

    logic [WIDTH-1:0]    in_valid;
    logic [WIDTH-1:0]    in_is_branch;
    logic [WIDTH-1:0]    in_uses_rd;
    logic                ext_stall;
    logic                int_stall;
    logic                if_recall;
    logic [WIDTH-1:0]    out_valid;
    logic [WIDTH-1:0]    out_make_cp;
    logic [WIDTH*LW-1:0] out_alloc_slot;
    logic [CW-1:0]       out_alloc_count;
    logic [WIDTH*LW-1:0] out_cp_slot;
    logic [CW-1:0]       out_cp_count;
    logic                decode_hold;
    logic                split_active;
    logic [PERF_W-1:0]   perf_split_cnt;

    modport master (
        output in_valid, in_is_branch, in_uses_rd,
        output ext_stall, int_stall, if_recall,
        input  out_valid, out_make_cp, out_alloc_slot, out_alloc_count,
        input  out_cp_slot, out_cp_count, decode_hold, split_active,
        input  perf_split_cnt
    );

    modport slave (
        input  in_valid, in_is_branch, in_uses_rd,
        input  ext_stall, int_stall, if_recall,
        output out_valid, out_make_cp, out_alloc_slot, out_alloc_count,
        output out_cp_slot, out_cp_count, decode_hold, split_active,
        output perf_split_cnt
    );

endinterface

// File: rtl/rename_prefix_sum.sv
// Per-lane prefix popcount (exclusive or inclusive) plus the total.
module rename_prefix_sum
    import rename_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int PW        = 2,
    parameter bit INCLUSIVE = 1'b0
) (
    input  logic [WIDTH-1:0]           bits_i,
    output logic [WIDTH-1:0][PW-1:0]   pfx_o,
    output logic [clog2(WIDTH+1)-1:0]  total_o
);
    localparam int CW = clog2(WIDTH + 1);

    always_comb begin
        int acc;
        acc   = 0;
        pfx_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (INCLUSIVE) acc = acc + int'(bits_i[i]);
            pfx_o[i] = PW'(acc);
            if (!INCLUSIVE) acc = acc + int'(bits_i[i]);
        end
        total_o = CW'(acc);
    end

endmodule

// File: rtl/rename_group_splitter.sv
// Splits a decode group into in-order slices bounded by checkpoint bandwidth,
// and hands out per-lane free-list and checkpoint slots for each slice.
module rename_group_splitter
    import rename_pkg::*;
#(
    parameter int WIDTH            = 4,
    parameter int MAX_CP_PER_CYCLE = 1,
    parameter int PERF_W           = 16
) (
    input logic              clk,
    input logic              reset,
    rename_group_splitter_if.slave bus
);
    localparam int LW = clog2(WIDTH);
    localparam int CW = clog2(WIDTH + 1);

    split_state_e      state_q, state_d;
    logic [WIDTH-1:0]  pend_q, pend_d;
    logic [PERF_W-1:0] perf_q, perf_d;

    logic [WIDTH-1:0]          act, slice, rem, live, live_cp;
    logic [WIDTH-1:0][CW-1:0]  br_pfx;
    logic [CW-1:0]             br_total;
    logic [WIDTH-1:0][LW-1:0]  a_slot, c_slot;
    logic [CW-1:0]             a_cnt, c_cnt;
    logic                      over_cp, stalled, hold;

    assign act     = (state_q == NORMAL) ? bus.in_valid : pend_q;
    assign stalled = bus.ext_stall | bus.int_stall;

    rename_prefix_sum #(.WIDTH(WIDTH), .PW(CW), .INCLUSIVE(1'b1)) u_br (
        .bits_i  (act & bus.in_is_branch),
        .pfx_o   (br_pfx),
        .total_o (br_total)
    );

    // Prefix property: once the branch count passes the limit, so does every later lane.
    always_comb begin
        slice = '0;
        for (int i = 0; i < WIDTH; i++)
            slice[i] = act[i] && (int'(br_pfx[i]) <= MAX_CP_PER_CYCLE);
    end

    assign rem     = act & ~slice;
    assign over_cp = int'(br_total) > MAX_CP_PER_CYCLE;

    rename_prefix_sum #(.WIDTH(WIDTH), .PW(LW), .INCLUSIVE(1'b0)) u_alloc (
        .bits_i  (live & bus.in_uses_rd),
        .pfx_o   (a_slot),
        .total_o (a_cnt)
    );

    rename_prefix_sum #(.WIDTH(WIDTH), .PW(LW), .INCLUSIVE(1'b0)) u_cp (
        .bits_i  (live_cp),
        .pfx_o   (c_slot),
        .total_o (c_cnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= NORMAL;
            pend_q  <= '0;
            perf_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            perf_q  <= perf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        perf_d  = perf_q;
        if (bus.if_recall) begin
            state_d = NORMAL;
            pend_d  = '0;
        end else if (!stalled) begin
            if (over_cp) begin
                state_d = SPLIT;
                pend_d  = rem;
                if (state_q == NORMAL && perf_q != '1)
                    perf_d = perf_q + PERF_W'(1);
            end else begin
                state_d = NORMAL;
                pend_d  = '0;
            end
        end
    end

    // Reset gates the outputs directly so they drop without a clock edge.
    always_comb begin
        live = slice;
        hold = over_cp | stalled;
        if (reset || bus.if_recall) begin
            live = '0;
            hold = 1'b0;
        end
        live_cp = live & bus.in_is_branch;
    end

    assign bus.out_valid       = live;
    assign bus.out_make_cp     = live_cp;
    assign bus.out_alloc_slot  = a_slot;
    assign bus.out_alloc_count = a_cnt;
    assign bus.out_cp_slot     = c_slot;
    assign bus.out_cp_count    = c_cnt;
    assign bus.decode_hold     = hold;
    assign bus.split_active    = (state_q == SPLIT);
    assign bus.perf_split_cnt  = perf_q;

endmodule

// File: tb/tb_rename_group_splitter.sv
// Directed scenarios plus randomized groups checked against a slice-bucket model.
module tb_rename_group_splitter;
    import rename_pkg::*;

    localparam int W  = 4;
    localparam int LW = clog2(W);
    localparam int CW = clog2(W + 1);
    localparam int PW = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   perf_m[2] = '{0, 0};

    always #5 clk = ~clk;

    rename_group_splitter_if #(.WIDTH(W), .PERF_W(PW)) ba ();
    rename_group_splitter_if #(.WIDTH(W), .PERF_W(PW)) bb ();

    rename_group_splitter #(.WIDTH(W), .MAX_CP_PER_CYCLE(1), .PERF_W(PW)) dut_a (
        .clk(clk), .reset(reset), .bus(ba.slave));
    rename_group_splitter #(.WIDTH(W), .MAX_CP_PER_CYCLE(2), .PERF_W(PW)) dut_b (
        .clk(clk), .reset(reset), .bus(bb.slave));

    logic [W-1:0]    o_v, o_cp;
    logic [W*LW-1:0] o_as, o_cs;
    logic [CW-1:0]   o_ac, o_cc;
    logic            o_hold, o_split;
    logic [PW-1:0]   o_perf;

    task automatic drive(input int d, input logic [W-1:0] v, input logic [W-1:0] b,
                         input logic [W-1:0] r, input logic es, input logic ist,
                         input logic rc);
        if (d == 0) begin
            ba.in_valid = v; ba.in_is_branch = b; ba.in_uses_rd = r;
            ba.ext_stall = es; ba.int_stall = ist; ba.if_recall = rc;
        end else begin
            bb.in_valid = v; bb.in_is_branch = b; bb.in_uses_rd = r;
            bb.ext_stall = es; bb.int_stall = ist; bb.if_recall = rc;
        end
    endtask

    task automatic sample(input int d);
        if (d == 0) begin
            o_v = ba.out_valid; o_cp = ba.out_make_cp;
            o_as = ba.out_alloc_slot; o_cs = ba.out_cp_slot;
            o_ac = ba.out_alloc_count; o_cc = ba.out_cp_count;
            o_hold = ba.decode_hold; o_split = ba.split_active;
            o_perf = ba.perf_split_cnt;
        end else begin
            o_v = bb.out_valid; o_cp = bb.out_make_cp;
            o_as = bb.out_alloc_slot; o_cs = bb.out_cp_slot;
            o_ac = bb.out_alloc_count; o_cc = bb.out_cp_count;
            o_hold = bb.decode_hold; o_split = bb.split_active;
            o_perf = bb.perf_split_cnt;
        end
    endtask

    function automatic int slot(input logic [W*LW-1:0] s, input int i);
        return int'(s[i*LW +: LW]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 4'b1111, 4'b0101, 4'b1111, 1'b1, 1'b0, 1'b0);
        drive(1, 4'b1111, 4'b1111, 4'b1111, 1'b0, 1'b1, 1'b0);
        #3;
        sample(0);
        n_chk++; if (o_v !== 4'b0000) begin n_fail++; $display("FAIL rst_valid: got %b want 0000", o_v); end
        n_chk++; if (o_cp !== 4'b0000) begin n_fail++; $display("FAIL rst_cp: got %b want 0000", o_cp); end
        n_chk++; if (o_ac !== '0 || o_cc !== '0) begin n_fail++; $display("FAIL rst_counts: got %0d/%0d want 0/0", o_ac, o_cc); end
        n_chk++; if (o_as !== '0 || o_cs !== '0) begin n_fail++; $display("FAIL rst_slots: got %h/%h want 0/0", o_as, o_cs); end
        n_chk++; if (o_hold !== 1'b0) begin n_fail++; $display("FAIL rst_hold: got %b want 0", o_hold); end
        n_chk++; if (o_split !== 1'b0 || o_perf !== '0) begin n_fail++; $display("FAIL rst_state: got split=%b perf=%0d want 0/0", o_split, o_perf); end
        sample(1);
        n_chk++; if (o_v !== 4'b0000 || o_hold !== 1'b0) begin n_fail++; $display("FAIL rst_b: got valid=%b hold=%b want 0000/0", o_v, o_hold); end
        reset = 1'b0;
        drive(0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        drive(1, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_no_branch();
        drive(0, 4'b1111, 4'b0000, 4'b1011, 1'b0, 1'b0, 1'b0);
        #1 sample(0);
        n_chk++; if (o_v !== 4'b1111) begin n_fail++; $display("FAIL nb_valid: got %b want 1111", o_v); end
        n_chk++; if (slot(o_as, 0) != 0 || slot(o_as, 1) != 1 || slot(o_as, 3) != 2) begin
            n_fail++; $display("FAIL nb_slots: got %0d,%0d,%0d want 0,1,2", slot(o_as, 0), slot(o_as, 1), slot(o_as, 3)); end
        n_chk++; if (o_ac !== 3'd3) begin n_fail++; $display("FAIL nb_count: got %0d want 3", o_ac); end
        n_chk++; if (o_hold !== 1'b0) begin n_fail++; $display("FAIL nb_hold: got %b want 0", o_hold); end
        tick();
        sample(0);
        n_chk++; if (o_split !== 1'b0) begin n_fail++; $display("FAIL nb_state: got split=%b want 0", o_split); end
        drive(0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_two_branch();
        drive(0, 4'b1111, 4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0);
        #1 sample(0);
        n_chk++; if (o_v !== 4'b0011 || o_cp !== 4'b0001) begin n_fail++; $display("FAIL tb_c0: got valid=%b cp=%b want 0011/0001", o_v, o_cp); end
        n_chk++; if (o_hold !== 1'b1) begin n_fail++; $display("FAIL tb_c0_hold: got %b want 1", o_hold); end
        tick();
        perf_m[0]++;
        drive(0, 4'b0000, 4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0);
        #1 sample(0);
        n_chk++; if (o_v !== 4'b1100 || o_cp !== 4'b0100) begin n_fail++; $display("FAIL tb_c1: got valid=%b cp=%b want 1100/0100", o_v, o_cp); end
        n_chk++; if (slot(o_cs, 2) != 0 || o_cc !== 3'd1) begin n_fail++; $display("FAIL tb_c1_cp: got slot=%0d cnt=%0d want 0/1", slot(o_cs, 2), o_cc); end
        n_chk++; if (o_hold !== 1'b0 || o_split !== 1'b1) begin n_fail++; $display("FAIL tb_c1_ctl: got hold=%b split=%b want 0/1", o_hold, o_split); end
        n_chk++; if (o_perf !== PW'(perf_m[0])) begin n_fail++; $display("FAIL tb_perf: got %0d want %0d", o_perf, perf_m[0]); end
        tick();
        sample(0);
        n_chk++; if (o_split !== 1'b0 || o_v !== 4'b0000) begin n_fail++; $display("FAIL tb_done: got split=%b valid=%b want 0/0000", o_split, o_v); end
    endtask

    task automatic test_all_branch();
        logic [W-1:0] ev;
        drive(0, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            #1 sample(0);
            ev = '0;
            ev[c] = 1'b1;
            n_chk++; if (o_v !== ev) begin n_fail++; $display("FAIL ab_valid%0d: got %b want %b", c, o_v, ev); end
            n_chk++; if (o_hold !== (c < 3)) begin n_fail++; $display("FAIL ab_hold%0d: got %b want %b", c, o_hold, c < 3); end
            tick();
            if (c == 0) perf_m[0]++;
        end
        drive(0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        #1 sample(0);
        n_chk++; if (o_perf !== PW'(perf_m[0]) || o_split !== 1'b0) begin n_fail++; $display("FAIL ab_end: got perf=%0d split=%b want %0d/0", o_perf, o_split, perf_m[0]); end
        drive(1, 4'b1111, 4'b0111, 4'b0000, 1'b0, 1'b0, 1'b0);
        #1 sample(1);
        n_chk++; if (o_v !== 4'b0011 || o_hold !== 1'b1) begin n_fail++; $display("FAIL ab2_c0: got valid=%b hold=%b want 0011/1", o_v, o_hold); end
        n_chk++; if (o_cc !== 3'd2 || slot(o_cs, 1) != 1) begin n_fail++; $display("FAIL ab2_cp: got cnt=%0d slot1=%0d want 2/1", o_cc, slot(o_cs, 1)); end
        tick();
        perf_m[1]++;
        sample(1);
        n_chk++; if (o_v !== 4'b1100 || o_cp !== 4'b0100 || o_hold !== 1'b0) begin n_fail++; $display("FAIL ab2_c1: got valid=%b cp=%b hold=%b want 1100/0100/0", o_v, o_cp, o_hold); end
        tick();
        drive(1, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        #1 sample(1);
        n_chk++; if (o_perf !== PW'(perf_m[1])) begin n_fail++; $display("FAIL ab2_perf: got %0d want %0d", o_perf, perf_m[1]); end
    endtask

    task automatic test_recall();
        drive(0, 4'b1111, 4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        perf_m[0]++;
        drive(0, 4'b1111, 4'b0101, 4'b0000, 1'b0, 1'b0, 1'b1);
        #1 sample(0);
        n_chk++; if (o_v !== 4'b0000 || o_cp !== 4'b0000 || o_hold !== 1'b0) begin n_fail++; $display("FAIL rc_out: got valid=%b cp=%b hold=%b want 0000/0000/0", o_v, o_cp, o_hold); end
        tick();
        drive(0, 4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0);
        #1 sample(0);
        n_chk++; if (o_v !== 4'b0001 || o_split !== 1'b0 || o_hold !== 1'b0) begin n_fail++; $display("FAIL rc_next: got valid=%b split=%b hold=%b want 0001/0/0", o_v, o_split, o_hold); end
        tick();
        drive(0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_stall_split();
        drive(0, 4'b1111, 4'b0101, 4'b0000, 1'b0, 1'b1, 1'b0);
        #1 sample(0);
        n_chk++; if (o_v !== 4'b0011 || o_hold !== 1'b1) begin n_fail++; $display("FAIL st_c0: got valid=%b hold=%b want 0011/1", o_v, o_hold); end
        tick();
        sample(0);
        n_chk++; if (o_split !== 1'b0 || o_perf !== PW'(perf_m[0])) begin n_fail++; $display("FAIL st_nostep: got split=%b perf=%0d want 0/%0d", o_split, o_perf, perf_m[0]); end
        drive(0, 4'b1111, 4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        perf_m[0]++;
        drive(0, 4'b1111, 4'b0101, 4'b0000, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1 sample(0);
            n_chk++; if (o_v !== 4'b1100 || o_hold !== 1'b1 || o_split !== 1'b1) begin n_fail++; $display("FAIL st_hold%0d: got valid=%b hold=%b split=%b want 1100/1/1", k, o_v, o_hold, o_split); end
            tick();
        end
        drive(0, 4'b1111, 4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0);
        #1 sample(0);
        n_chk++; if (o_v !== 4'b1100 || o_hold !== 1'b0) begin n_fail++; $display("FAIL st_rel: got valid=%b hold=%b want 1100/0", o_v, o_hold); end
        tick();
        drive(0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        #1 sample(0);
        n_chk++; if (o_split !== 1'b0 || o_v !== 4'b0000 || o_perf !== PW'(perf_m[0])) begin n_fail++; $display("FAIL st_done: got split=%b valid=%b perf=%0d want 0/0000/%0d", o_split, o_v, o_perf, perf_m[0]); end
    endtask

    task automatic test_random(input int d, input int maxcp, input int ngroups);
        logic [W-1:0] v, b, r, ev, ecp;
        logic es, ist, rc, eh;
        int cyc[W];
        int ncyc, bc, c, guard, ac, cc;
        for (int g = 0; g < ngroups; g++) begin
            v = W'($urandom);
            b = W'($urandom);
            r = W'($urandom);
            bc = 0;
            ncyc = 1;
            for (int i = 0; i < W; i++) begin
                cyc[i] = -1;
                if (v[i]) begin
                    bc += int'(b[i]);
                    cyc[i] = (bc == 0) ? 0 : (bc - 1) / maxcp;
                    if (cyc[i] + 1 > ncyc) ncyc = cyc[i] + 1;
                end
            end
            c = 0;
            guard = 0;
            while (c < ncyc && guard < 64) begin
                guard++;
                es  = ($urandom_range(0, 3) == 0);
                ist = ($urandom_range(0, 4) == 0);
                rc  = ($urandom_range(0, 15) == 0);
                drive(d, (c == 0) ? v : W'($urandom), b, r, es, ist, rc);
                #1 sample(d);
                ev = '0;
                for (int i = 0; i < W; i++) ev[i] = v[i] && (cyc[i] == c) && !rc;
                ecp = ev & b;
                eh = !rc && ((c < ncyc - 1) || es || ist);
                n_chk++; if (o_v !== ev) begin n_fail++; $display("FAIL rnd_valid d%0d g%0d c%0d: got %b want %b", d, g, c, o_v, ev); end
                n_chk++; if (o_cp !== ecp) begin n_fail++; $display("FAIL rnd_cp d%0d g%0d c%0d: got %b want %b", d, g, c, o_cp, ecp); end
                n_chk++; if (o_hold !== eh) begin n_fail++; $display("FAIL rnd_hold d%0d g%0d c%0d: got %b want %b", d, g, c, o_hold, eh); end
                n_chk++; if (o_split !== (c > 0)) begin n_fail++; $display("FAIL rnd_split d%0d g%0d c%0d: got %b want %b", d, g, c, o_split, c > 0); end
                n_chk++; if (o_perf !== PW'(perf_m[d])) begin n_fail++; $display("FAIL rnd_perf d%0d g%0d: got %0d want %0d", d, g, o_perf, perf_m[d]); end
                ac = 0;
                cc = 0;
                for (int i = 0; i < W; i++) begin
                    if (ev[i] && r[i]) begin
                        n_chk++; if (slot(o_as, i) != ac) begin n_fail++; $display("FAIL rnd_aslot d%0d g%0d lane%0d: got %0d want %0d", d, g, i, slot(o_as, i), ac); end
                        ac++;
                    end
                    if (ecp[i]) begin
                        n_chk++; if (slot(o_cs, i) != cc) begin n_fail++; $display("FAIL rnd_cslot d%0d g%0d lane%0d: got %0d want %0d", d, g, i, slot(o_cs, i), cc); end
                        cc++;
                    end
                end
                n_chk++; if (int'(o_ac) != ac || int'(o_cc) != cc) begin n_fail++; $display("FAIL rnd_counts d%0d g%0d: got %0d/%0d want %0d/%0d", d, g, o_ac, o_cc, ac, cc); end
                tick();
                if (rc) c = ncyc;
                else if (!es && !ist) begin
                    if (c == 0 && ncyc > 1) perf_m[d]++;
                    c++;
                end
            end
            n_chk++; if (c < ncyc) begin n_fail++; $display("FAIL rnd_guard d%0d g%0d: got cycle %0d want %0d", d, g, c, ncyc); end
        end
        drive(d, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_async_reset();
        drive(0, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        perf_m[0]++;
        #1 sample(0);
        n_chk++; if (o_v !== 4'b1000 || o_split !== 1'b1) begin n_fail++; $display("FAIL ar_pre: got valid=%b split=%b want 1000/1", o_v, o_split); end
        #1 reset = 1'b1;
        #1 sample(0);
        n_chk++; if (o_v !== 4'b0000 || o_cp !== 4'b0000 || o_hold !== 1'b0) begin n_fail++; $display("FAIL ar_out: got valid=%b cp=%b hold=%b want 0000/0000/0", o_v, o_cp, o_hold); end
        n_chk++; if (o_split !== 1'b0 || o_perf !== '0) begin n_fail++; $display("FAIL ar_state: got split=%b perf=%0d want 0/0", o_split, o_perf); end
        perf_m[0] = 0;
        perf_m[1] = 0;
        #2 reset = 1'b0;
        #1 sample(0);
        n_chk++; if (o_v !== 4'b0001 || o_split !== 1'b0 || o_hold !== 1'b1) begin n_fail++; $display("FAIL ar_post: got valid=%b split=%b hold=%b want 0001/0/1", o_v, o_split, o_hold); end
        drive(0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        test_reset();
        test_no_branch();
        test_two_branch();
        test_all_branch();
        test_recall();
        test_stall_split();
        test_random(0, 1, 150);
        test_random(1, 2, 150);
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
